// File: rtl/la_pkg.sv
// Shared types and default sizing for the logic-analyzer capture path.
package la_pkg;

  localparam int unsigned LA_ENTRIES = 384;
  localparam int unsigned LA_AW      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cap_addr_cnt.sv
// Trace RAM write address counter: clears to 0, advances on inc, wraps after ENTRIES-1.
module cap_addr_cnt
  import la_pkg::*;
#(
  parameter int unsigned ENTRIES = LA_ENTRIES,
  parameter int unsigned AW      = LA_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = (addr_q == AW'(ENTRIES - 1)) ? '0 : addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition sequencer: arms trigger_logic once the pre-trigger history is full,
// fills the circular trace RAM, counts post-trigger samples and reports completion.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned ENTRIES = LA_ENTRIES,
  parameter int unsigned AW      = LA_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_cap,
  input  logic          abort,
  input  logic          clr_cap_done,
  input  logic          wrt_smpl,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          set_capture_done,
  output logic          capture_done,
  output logic [AW-1:0] trace_end,
  output logic          capturing
);

  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_POST = 2'(POST);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] smpl_cnt_q, smpl_cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] tpos_q, tpos_d;
  logic [AW-1:0] trace_end_q, trace_end_d;
  logic          armed_q, armed_d;
  logic          scd_q, scd_d;
  logic          cdone_q, cdone_d;
  logic          enter_done;
  logic          addr_clr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] post_cnt_inc;

  assign capturing    = (state_q == ST_RUN) || (state_q == ST_POST);
  assign we           = wrt_smpl & capturing;
  assign addr_clr     = run_cap & ~abort;
  assign post_cnt_inc = post_cnt_q + AW'(1);
  // Address of the most recent write, including one landing this cycle.
  assign last_addr    = we ? waddr :
                        ((waddr == '0) ? AW'(ENTRIES - 1) : waddr - AW'(1));

  cap_addr_cnt #(
    .ENTRIES(ENTRIES),
    .AW     (AW)
  ) u_addr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (addr_clr),
    .inc_i (we),
    .addr_o(waddr)
  );

  always_comb begin
    state_d     = state_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    tpos_d      = tpos_q;
    trace_end_d = trace_end_q;
    armed_d     = 1'b0;
    scd_d       = 1'b0;
    cdone_d     = clr_cap_done ? 1'b0 : cdone_q;
    enter_done  = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else if (run_cap) begin
      state_d    = ST_RUN;
      smpl_cnt_d = '0;
      post_cnt_d = '0;
      cdone_d    = 1'b0;
      tpos_d     = (trig_pos > AW'(ENTRIES - 1)) ? AW'(ENTRIES - 1) : trig_pos;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (we && (smpl_cnt_q != CW'(ENTRIES))) begin
            smpl_cnt_d = smpl_cnt_q + CW'(1);
          end
          if (triggered && armed_q) begin
            if (tpos_q == '0) begin
              enter_done = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            // Arm only once enough history exists to fill the pre-trigger window.
            armed_d = (smpl_cnt_q >= (CW'(ENTRIES) - CW'(tpos_q)));
          end
        end
        ST_POST: begin
          if (we) begin
            post_cnt_d = post_cnt_inc;
            if (post_cnt_inc == tpos_q) begin
              enter_done = 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (enter_done) begin
        state_d     = ST_DONE;
        scd_d       = 1'b1;
        cdone_d     = 1'b1;
        trace_end_d = last_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      tpos_q      <= '0;
      trace_end_q <= '0;
      armed_q     <= 1'b0;
      scd_q       <= 1'b0;
      cdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      tpos_q      <= tpos_d;
      trace_end_q <= trace_end_d;
      armed_q     <= armed_d;
      scd_q       <= scd_d;
      cdone_q     <= cdone_d;
    end
  end

  assign armed            = armed_q;
  assign set_capture_done = scd_q;
  assign capture_done     = cdone_q;
  assign trace_end        = trace_end_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl with an acquisition-level reference model.
module tb_capture_ctrl;

  localparam int unsigned E  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_cap, abort, clr_cap_done, wrt_smpl, triggered;
  logic [AW-1:0] trig_pos;
  logic          we, armed, set_capture_done, capture_done, capturing;
  logic [AW-1:0] waddr, trace_end;

  capture_ctrl #(.ENTRIES(E), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .run_cap         (run_cap),
    .abort           (abort),
    .clr_cap_done    (clr_cap_done),
    .wrt_smpl        (wrt_smpl),
    .triggered       (triggered),
    .trig_pos        (trig_pos),
    .we              (we),
    .waddr           (waddr),
    .armed           (armed),
    .set_capture_done(set_capture_done),
    .capture_done    (capture_done),
    .trace_end       (trace_end),
    .capturing       (capturing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 pre-trigger, 2 post-trigger, 3 done.
  int m_phase = 0;
  int m_nwr   = 0;   // writes since the last run_cap
  int m_post  = 0;   // post-trigger writes
  int m_tpos  = 0;
  int m_te    = 0;
  bit m_armed = 1'b0;
  bit m_scd   = 1'b0;
  bit m_cd    = 1'b0;
  bit mon_en  = 1'b0;
  int exp_q[$];
  int scd_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every cycle against the model and pops on each completion pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we", int'(we), int'(wrt_smpl && (m_phase == 1 || m_phase == 2)));
      chk("waddr", int'(waddr), m_nwr % E);
      chk("armed", int'(armed), int'(m_armed));
      chk("capturing", int'(capturing), int'(m_phase == 1 || m_phase == 2));
      chk("capture_done", int'(capture_done), int'(m_cd));
      chk("set_capture_done", int'(set_capture_done), int'(m_scd));
      chk("trace_end", int'(trace_end), m_te);
      if (set_capture_done === 1'b1) begin
        scd_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("done_trace_end", int'(trace_end), exp_q.pop_front());
        end
      end
    end
  end

  // Predict next state from this cycle's inputs, then advance one clock.
  task automatic cycle(input bit r, input bit a, input bit c, input bit w,
                       input bit t, input int tp);
    int  n_phase, n_nwr, n_post, n_tpos, n_te;
    bit  n_armed, n_scd, n_cd, wr, fin;
    run_cap = r; abort = a; clr_cap_done = c; wrt_smpl = w; triggered = t;
    trig_pos = AW'(tp);
    wr      = w && (m_phase == 1 || m_phase == 2);
    n_phase = m_phase; n_post = m_post; n_tpos = m_tpos; n_te = m_te;
    n_nwr   = m_nwr + (wr ? 1 : 0);
    n_armed = 1'b0; n_scd = 1'b0; n_cd = c ? 1'b0 : m_cd; fin = 1'b0;
    if (rst) begin
      n_phase = 0; n_nwr = 0; n_post = 0; n_tpos = 0; n_te = 0; n_cd = 1'b0;
    end else if (a) begin
      n_phase = 0;
    end else if (r) begin
      n_phase = 1; n_nwr = 0; n_post = 0; n_cd = 1'b0;
      n_tpos = (tp > int'(E - 1)) ? int'(E - 1) : tp;
    end else if (m_phase == 1) begin
      if (t && m_armed) begin
        if (m_tpos == 0) fin = 1'b1;
        else n_phase = 2;
      end else begin
        n_armed = ((m_nwr < int'(E)) ? m_nwr : int'(E)) >= int'(E) - m_tpos;
      end
    end else if (m_phase == 2) begin
      if (wr) begin
        n_post = m_post + 1;
        if (n_post == m_tpos) fin = 1'b1;
      end
    end
    if (fin) begin
      n_phase = 3; n_scd = 1'b1; n_cd = 1'b1;
      n_te = (n_nwr + int'(E) - 1) % int'(E);
      exp_q.push_back(n_te);
    end
    @(posedge clk);
    #1;
    m_phase = n_phase; m_nwr = n_nwr; m_post = n_post; m_tpos = n_tpos;
    m_te = n_te; m_armed = n_armed; m_scd = n_scd; m_cd = n_cd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    cycle(0, 0, 0, 1, 1, 0);
    mon_en = 1'b1;
    cycle(0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    cycle(0, 0, 0, 1, 0, 0);

    // Full capture with trig_pos=3; DONE entry coincides with clr_cap_done.
    cycle(1, 0, 0, 0, 0, 3);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 1, 0);
    chk("s2_trace_end", int'(trace_end), 1);
    chk("s2_done_set_wins", int'(capture_done), 1);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("s2_clr", int'(capture_done), 0);

    // trig_pos=0: trigger write counts as pre-trigger, straight to DONE.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    idle(2);
    chk("s3_trace_end", int'(trace_end), 1);

    // Run in DONE restarts; early trigger is ignored until armed.
    base = scd_seen;
    cycle(1, 0, 0, 0, 0, 2);
    chk("s6_restart_waddr", int'(waddr), 0);
    chk("s6_restart_cd", int'(capture_done), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);
    chk("s4_still_run", int'(capturing), 1);
    chk("s4_no_done", scd_seen, base);

    // Abort during POST, then abort together with run_cap.
    cycle(1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 1, 0, 1, 1, 0);
    chk("s5_abort_idle", int'(capturing), 0);
    chk("s5_abort_armed", int'(armed), 0);
    idle(6);
    chk("s5_no_done", scd_seen, base);
    cycle(1, 1, 0, 1, 0, 5);
    chk("s5_abort_beats_run", int'(capturing), 0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 50) == 0, ($urandom % 150) == 0, ($urandom % 25) == 0,
            ($urandom % 10) < 7, ($urandom % 5) == 0, int'($urandom % E));
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
